// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - register file bus: two ID-stage read ports and one WB write port
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  read_en_1;
  logic [ADDR_WIDTH-1:0] read_addr_1;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic                  read_en_2;
  logic [ADDR_WIDTH-1:0] read_addr_2;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output read_en_1, read_addr_1, read_en_2, read_addr_2,
    output write_en, write_addr, write_data,
    input  read_data_1, read_data_2
  );

  modport slave (
    input  read_en_1, read_addr_1, read_en_2, read_addr_2,
    input  write_en, write_addr, write_data,
    output read_data_1, read_data_2
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 MIPS register file, $zero hardwired, combinational reads
// Optional write-first bypass enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_file_if.slave   rf
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] read_data_1_d;
  logic [DATA_WIDTH-1:0] read_data_2_d;
  logic                  write_hit_d;

  assign write_hit_d = rf.write_en && (rf.write_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_hit_d) begin
      regs_q[rf.write_addr] <= rf.write_data;
    end
  end

  // Address 0 short-circuits before any bypass so $zero never forwards a write.
  always_comb begin
    read_data_1_d = '0;
    if (rst_n && rf.read_en_1 && (rf.read_addr_1 != '0)) begin
      read_data_1_d = regs_q[rf.read_addr_1];
`ifdef REGFILE_BYPASS_EN
      if (rf.write_en && (rf.write_addr == rf.read_addr_1)) begin
        read_data_1_d = rf.write_data;
      end
`endif
    end
  end

  always_comb begin
    read_data_2_d = '0;
    if (rst_n && rf.read_en_2 && (rf.read_addr_2 != '0)) begin
      read_data_2_d = regs_q[rf.read_addr_2];
`ifdef REGFILE_BYPASS_EN
      if (rf.write_en && (rf.write_addr == rf.read_addr_2)) begin
        read_data_2_d = rf.write_data;
      end
`endif
    end
  end

  assign rf.read_data_1 = read_data_1_d;
  assign rf.read_data_2 = read_data_2_d;
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed vector bench for reg_file (either REGFILE_BYPASS_EN build)
module tb_reg_file;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  vec_t tbl[$];

  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic re1, input logic [4:0] ra1,
                              input logic re2, input logic [4:0] ra2,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.rst_n = r;  v.we = we;   v.wa = wa;   v.wd = wd;
    v.re1 = re1;  v.ra1 = ra1; v.re2 = re2; v.ra2 = ra2;
    v.e1 = e1;    v.e2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2);
    bus.write_en = we;    bus.write_addr = wa;   bus.write_data = wd;
    bus.read_en_1 = re1;  bus.read_addr_1 = ra1;
    bus.read_en_2 = re2;  bus.read_addr_2 = ra2;
  endtask

  // Each vector/write occupies one cycle: driven at negedge, committed at the next posedge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(1'b1, a, d, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic rd2(input string name, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] e1, input logic [31:0] e2);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, a1, 1'b1, a2);
    #1;
    check($sformatf("%s p1 r%0d", name, a1), bus.read_data_1, e1);
    check($sformatf("%s p2 r%0d", name, a2), bus.read_data_2, e2);
  endtask

  initial begin
    logic [31:0] v1, v2;
    n_vec = 0;
    n_err = 0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    tbl.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 1, 5'd5, 32'h0, 32'h0));
    tbl.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 1, 5'd5, 32'h0, 32'h0));
    tbl.push_back(mk(1, 0, 5'd0, 32'h0,        1, 5'd5, 1, 5'd5, 32'h0, 32'h0));
    tbl.push_back(mk(1, 1, 5'd7, 32'h12345678, 1, 5'd5, 1, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 0, 5'd0, 32'h0,        1, 5'd7, 1, 5'd7, 32'h12345678, 32'h12345678));
    tbl.push_back(mk(1, 0, 5'd0, 32'h0,        1, 5'd7, 0, 5'd7, 32'h12345678, 32'h0));
    tbl.push_back(mk(1, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 0, 5'd0, 32'h0,        1, 5'd0, 1, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 1, 5'd3, 32'h11,       1, 5'd7, 1, 5'd0, 32'h12345678, 32'h0));
    tbl.push_back(mk(1, 1, 5'd3, 32'h22,       1, 5'd3, 1, 5'd7, BYP ? 32'h22 : 32'h11, 32'h12345678));
    tbl.push_back(mk(1, 0, 5'd0, 32'h0,        1, 5'd3, 1, 5'd3, 32'h22, 32'h22));
    tbl.push_back(mk(1, 1, 5'd3, 32'h33,       0, 5'd3, 1, 5'd3, 32'h0, BYP ? 32'h33 : 32'h22));
    tbl.push_back(mk(1, 0, 5'd0, 32'h0,        1, 5'd3, 1, 5'd3, 32'h33, 32'h33));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n;
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re1, tbl[i].ra1, tbl[i].re2, tbl[i].ra2);
      #1;
      check($sformatf("vec[%0d] p1", i), bus.read_data_1, tbl[i].e1);
      check($sformatf("vec[%0d] p2", i), bus.read_data_2, tbl[i].e2);
    end

    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    rd2("fill", 5'd1, 5'd31, 32'd1, 32'd31);

    // Reset dropped between edges with a write pending: reads clear at once, write is lost.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive(1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 5'd1, 1'b1, 5'd31);
    #1;
    check("async rst p1 r1", bus.read_data_1, 32'h0);
    check("async rst p2 r31", bus.read_data_2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
    rd2("post rst", 5'd31, 5'd30, 32'hA5A5A5A5, 32'h0);
    rd2("lost wr", 5'd9, 5'd1, 32'h0, 32'h0);

    for (int i = 1; i < 32; i++) wr(5'(i), ~32'(i));
    for (int i = 0; i < 32; i++) begin
      v1 = (i == 0) ? 32'h0 : ~32'(i);
      v2 = (i == 31) ? 32'h0 : ~32'(31 - i);
      rd2("sweep", 5'(i), 5'(31 - i), v1, v2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
